// File: rtl/mc_cpu.sv
// Multi-cycle accumulator-free register CPU: FETCH -> EXEC -> WB per instruction,
// with a combinational-read register file and a byte-addressed 32-bit PC.
module mc_cpu #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3
) (
    input  logic        clk,
    input  logic        reset,        // active-low, asynchronous
    output logic [31:0] pc,
    output logic        instr_req,
    input  logic [31:0] instruction,
    input  logic        instr_valid,
    output logic        retire,
    output logic        halted
);
    localparam int NREGS = 2**REG_AW;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_BNE   = 8'h08;
    localparam logic [7:0] OP_HALT  = 8'h09;

    typedef enum logic [1:0] {FETCH, EXEC, WB, HALT} state_t;

    state_t            state, state_nxt;
    logic [31:0]       ir;
    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] alu_q;
    logic              zero_q;

    logic [7:0]        opcode, offset, imm;
    logic [REG_AW-1:0] rd, rs1, rs2;
    logic [DATA_W-1:0] a, b, imm_sx, diff, alu_d;
    logic [31:0]       pc_seq, pc_br, pc_nxt;

    assign opcode = ir[31:24];
    assign offset = ir[23:16];
    assign imm    = ir[7:0];
    assign rd     = ir[16 +: REG_AW];
    assign rs1    = ir[8 +: REG_AW];
    assign rs2    = ir[0 +: REG_AW];

    assign a      = regs[rs1];
    assign b      = regs[rs2];
    assign imm_sx = DATA_W'($signed(imm));
    // Subtraction as add of the two's complement; also feeds the ZERO flag.
    assign diff   = a + (~b + 1'b1);

    always_comb begin
        alu_d = '0;
        case (opcode)
            OP_LOADI: alu_d = imm_sx;
            OP_MOV:   alu_d = b;
            OP_ADD:   alu_d = a + b;
            OP_SUB:   alu_d = diff;
            OP_AND:   alu_d = a & b;
            OP_OR:    alu_d = a | b;
            default:  alu_d = '0;
        endcase
    end

    assign pc_seq = pc + 32'd4;
    assign pc_br  = pc_seq + {{22{offset[7]}}, offset, 2'b00};

    always_comb begin
        pc_nxt = pc_seq;
        case (opcode)
            OP_J:    pc_nxt = pc_br;
            OP_BEQ:  pc_nxt = zero_q ? pc_br : pc_seq;
            OP_BNE:  pc_nxt = zero_q ? pc_seq : pc_br;
            OP_HALT: pc_nxt = pc;
            default: pc_nxt = pc_seq;
        endcase
    end

    always_comb begin
        state_nxt = state;
        instr_req = 1'b0;
        retire    = 1'b0;
        halted    = 1'b0;
        case (state)
            FETCH: begin
                instr_req = reset;
                if (instr_valid) state_nxt = EXEC;
            end
            EXEC: state_nxt = WB;
            WB: begin
                retire    = 1'b1;
                state_nxt = (opcode == OP_HALT) ? HALT : FETCH;
            end
            HALT: halted = 1'b1;
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= FETCH;
            pc     <= '0;
            ir     <= '0;
            alu_q  <= '0;
            zero_q <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                FETCH: if (instr_valid) ir <= instruction;
                EXEC: begin
                    alu_q  <= alu_d;
                    zero_q <= (diff == '0);
                end
                WB: begin
                    if (opcode <= OP_OR) regs[rd] <= alu_q;
                    pc <= pc_nxt;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_cpu.sv
// Directed bench for mc_cpu: an 8-bit/8-reg core and a 16-bit/16-reg core share stimulus.
module tb_mc_cpu;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instruction = '0;
    logic        instr_valid = 1'b0;

    logic [31:0] pc8, pc16;
    logic        req8, req16, ret8, ret16, hlt8, hlt16;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mc_cpu #(.DATA_W(8), .REG_AW(3)) dut8 (
        .clk(clk), .reset(reset), .pc(pc8), .instr_req(req8),
        .instruction(instruction), .instr_valid(instr_valid),
        .retire(ret8), .halted(hlt8));

    mc_cpu #(.DATA_W(16), .REG_AW(4)) dut16 (
        .clk(clk), .reset(reset), .pc(pc16), .instr_req(req16),
        .instruction(instruction), .instr_valid(instr_valid),
        .retire(ret16), .halted(hlt16));

    function automatic logic [31:0] enc(input logic [7:0] op, input logic [7:0] d,
                                        input logic [7:0] s1, input logic [7:0] s2);
        return {op, d, s1, s2};
    endfunction

    task automatic do_reset();
        instr_valid = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    // Called #1 after a rising edge while in FETCH; returns #1 after WB's closing edge.
    task automatic issue(input logic [31:0] w, input string name);
        instruction = w;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (ret8 !== 1'b0 || req8 !== 1'b0) begin
            fails++;
            $display("FAIL %s exec: retire=%b req=%b want 0 0", name, ret8, req8);
        end
        @(posedge clk); #1;
        tests++;
        if (ret8 !== 1'b1) begin
            fails++;
            $display("FAIL %s wb_retire: got %b want 1", name, ret8);
        end
        @(posedge clk); #1;
        tests++;
        if (ret8 !== 1'b0) begin
            fails++;
            $display("FAIL %s post_retire: got %b want 0", name, ret8);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        instr_valid = 1'b1;
        repeat (2) @(posedge clk); #1;
        tests++;
        if (pc8 !== 32'h0 || req8 !== 1'b0 || ret8 !== 1'b0 || hlt8 !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: pc=%h req=%b ret=%b hlt=%b want 0 0 0 0",
                     pc8, req8, ret8, hlt8);
        end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (dut8.regs[i] !== 8'h00) begin
                fails++;
                $display("FAIL reset_reg%0d: got %h want 00", i, dut8.regs[i]);
            end
        end
        instr_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (req8 !== 1'b1 || pc8 !== 32'h0) begin
            fails++;
            $display("FAIL reset_release: req=%b pc=%h want 1 00000000", req8, pc8);
        end
    endtask

    task automatic test_alu();
        do_reset();
        issue(enc(8'h00, 8'd4, 8'd0, 8'd5), "loadi_r4");
        issue(enc(8'h00, 8'd2, 8'd0, 8'd9), "loadi_r2");
        issue(enc(8'h02, 8'd6, 8'd2, 8'd4), "add_r6");
        tests++;
        if (dut8.regs[6] !== 8'd14 || pc8 !== 32'd12) begin
            fails++;
            $display("FAIL add_result: r6=%h pc=%h want 0e 0000000c", dut8.regs[6], pc8);
        end
        issue(enc(8'h03, 8'd1, 8'd4, 8'd2), "sub_r1");
        issue(enc(8'h04, 8'd3, 8'd2, 8'd4), "and_r3");
        issue(enc(8'h05, 8'd5, 8'd2, 8'd4), "or_r5");
        issue(enc(8'h01, 8'd7, 8'd0, 8'd2), "mov_r7");
        issue(enc(8'h00, 8'd0, 8'd0, 8'h80), "loadi_neg");
        tests++;
        if (dut8.regs[1] !== 8'hFC || dut8.regs[3] !== 8'h01 || dut8.regs[5] !== 8'h0D ||
            dut8.regs[7] !== 8'h09) begin
            fails++;
            $display("FAIL alu_ops: r1=%h r3=%h r5=%h r7=%h want fc 01 0d 09",
                     dut8.regs[1], dut8.regs[3], dut8.regs[5], dut8.regs[7]);
        end
        tests++;
        if (dut8.regs[0] !== 8'h80 || dut16.regs[0] !== 16'hFF80) begin
            fails++;
            $display("FAIL imm_sext: r0_8=%h r0_16=%h want 80 ff80", dut8.regs[0], dut16.regs[0]);
        end
    endtask

    task automatic test_branch();
        do_reset();
        issue(enc(8'h00, 8'd1, 8'd0, 8'd5), "loadi_r1");
        issue(enc(8'h00, 8'd4, 8'd0, 8'd5), "loadi_r4");
        issue(enc(8'h07, 8'd2, 8'd1, 8'd4), "beq_taken");
        tests++;
        if (pc8 !== 32'd20) begin
            fails++;
            $display("FAIL beq_taken_pc: got %h want 00000014", pc8);
        end
        issue(enc(8'h08, 8'd5, 8'd1, 8'd4), "bne_not_taken");
        tests++;
        if (pc8 !== 32'd24) begin
            fails++;
            $display("FAIL bne_not_taken_pc: got %h want 00000018", pc8);
        end
        issue(enc(8'h00, 8'd2, 8'd0, 8'd3), "loadi_r2");
        issue(enc(8'h08, 8'd1, 8'd1, 8'd2), "bne_taken");
        tests++;
        if (pc8 !== 32'd36) begin
            fails++;
            $display("FAIL bne_taken_pc: got %h want 00000024", pc8);
        end
        issue(enc(8'h07, 8'd3, 8'd1, 8'd2), "beq_not_taken");
        tests++;
        if (pc8 !== 32'd40) begin
            fails++;
            $display("FAIL beq_not_taken_pc: got %h want 00000028", pc8);
        end
    endtask

    task automatic test_jump();
        do_reset();
        for (int i = 0; i < 4; i++) issue(enc(8'hAA, 8'd0, 8'd0, 8'd0), "nop_pad");
        issue(enc(8'h06, 8'hFE, 8'd0, 8'd0), "j_back");
        tests++;
        if (pc8 !== 32'd12) begin
            fails++;
            $display("FAIL j_back_pc: got %h want 0000000c", pc8);
        end
        issue(enc(8'h06, 8'hFB, 8'd0, 8'd0), "j_to_top");
        tests++;
        if (pc8 !== 32'hFFFFFFFC) begin
            fails++;
            $display("FAIL j_to_top_pc: got %h want fffffffc", pc8);
        end
        issue(enc(8'h06, 8'h7F, 8'd0, 8'd0), "j_wrap");
        tests++;
        if (pc8 !== 32'h000001FC) begin
            fails++;
            $display("FAIL j_wrap_pc: got %h want 000001fc", pc8);
        end
    endtask

    task automatic test_fetch_wait();
        do_reset();
        issue(enc(8'h00, 8'd3, 8'd0, 8'd7), "loadi_r3");
        instr_valid = 1'b0;
        instruction = enc(8'h00, 8'd3, 8'd0, 8'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests++;
            if (req8 !== 1'b1 || pc8 !== 32'd4 || ret8 !== 1'b0) begin
                fails++;
                $display("FAIL fetch_wait%0d: req=%b pc=%h ret=%b want 1 00000004 0",
                         i, req8, pc8, ret8);
            end
        end
        reset = 1'b0;
        #2;
        tests++;
        if (pc8 !== 32'h0 || dut8.regs[3] !== 8'h00 || req8 !== 1'b0) begin
            fails++;
            $display("FAIL wait_abort: pc=%h r3=%h req=%b want 0 00 0", pc8, dut8.regs[3], req8);
        end
    endtask

    task automatic test_wb_abort();
        do_reset();
        issue(enc(8'h00, 8'd1, 8'd0, 8'd2), "loadi_r1");
        instruction = enc(8'h00, 8'd5, 8'd0, 8'h33);
        instr_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (dut8.regs[5] !== 8'h00 || pc8 !== 32'h0 || ret8 !== 1'b0) begin
            fails++;
            $display("FAIL wb_abort: r5=%h pc=%h ret=%b want 00 0 0", dut8.regs[5], pc8, ret8);
        end
    endtask

    task automatic test_width16();
        do_reset();
        issue(enc(8'h00, 8'd15, 8'd0, 8'hFF), "loadi_r15");
        issue(enc(8'h00, 8'd1, 8'd0, 8'd1), "loadi_r1_16");
        issue(enc(8'h02, 8'd14, 8'd15, 8'd1), "add_r14");
        tests++;
        if (dut16.regs[14] !== 16'h0000 || dut16.regs[15] !== 16'hFFFF) begin
            fails++;
            $display("FAIL add16_wrap: r14=%h r15=%h want 0000 ffff", dut16.regs[14], dut16.regs[15]);
        end
        issue(enc(8'h03, 8'd13, 8'd1, 8'd15), "sub_r13");
        tests++;
        if (dut16.regs[13] !== 16'h0002 || pc16 !== 32'd16) begin
            fails++;
            $display("FAIL sub16: r13=%h pc=%h want 0002 00000010", dut16.regs[13], pc16);
        end
    endtask

    task automatic test_halt();
        do_reset();
        issue(enc(8'h00, 8'd2, 8'd0, 8'd9), "loadi_r2_h");
        issue(enc(8'hAA, 8'd2, 8'd2, 8'd2), "nop_aa");
        tests++;
        if (pc8 !== 32'd8 || dut8.regs[2] !== 8'd9) begin
            fails++;
            $display("FAIL nop_aa: pc=%h r2=%h want 00000008 09", pc8, dut8.regs[2]);
        end
        issue(enc(8'h09, 8'd2, 8'd0, 8'd7), "halt");
        for (int i = 0; i < 20; i++) begin
            instr_valid = ~instr_valid;
            tests++;
            if (hlt8 !== 1'b1 || req8 !== 1'b0 || ret8 !== 1'b0 || pc8 !== 32'd8) begin
                fails++;
                $display("FAIL halt_hold%0d: hlt=%b req=%b ret=%b pc=%h want 1 0 0 00000008",
                         i, hlt8, req8, ret8, pc8);
            end
            @(posedge clk); #1;
        end
        tests++;
        if (dut8.regs[2] !== 8'd9) begin
            fails++;
            $display("FAIL halt_nowrite: r2=%h want 09", dut8.regs[2]);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_jump();
        test_fetch_wait();
        test_wb_abort();
        test_width16();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
